// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: opcode/function encodings,
// the HALT match constants and the fetch sequencer state type.
package TopLevel_def;

   typedef enum logic [2:0] {
      R_ADD  = 3'd0,
      R_SUB  = 3'd1,
      R_AND  = 3'd2,
      R_OR   = 3'd3,
      LOAD   = 3'd4,
      STORE  = 3'd5,
      BRANCH = 3'd6,
      R_NEG  = 3'd7
   } Opcode;

   localparam logic [1:0] FUN_PASS = 2'd0;
   localparam logic [1:0] FUN_NEG  = 2'd1;
   localparam logic [1:0] FUN_NOT  = 2'd2;
   localparam logic [1:0] FUN_HALT = 2'd3;

   localparam Opcode      HALT_OPC = R_NEG;
   localparam logic [1:0] HALT_FUN = FUN_HALT;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      DRAIN  = 2'd2,
      HALTED = 2'd3
   } fetch_state_e;

   // HALT lives in the R_NEG opcode space, selected by the function field.
   function automatic logic is_halt(input logic [2:0] opc, input logic [1:0] fun);
      return (Opcode'(opc) == HALT_OPC) && (fun == HALT_FUN);
   endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding a returned instruction and its address while
// the output register is still occupied by an unaccepted instruction.
module fetch_skid_buf #(
   parameter int PC_W   = 10,
   parameter int INST_W = 9
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr_i,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [INST_W-1:0] inst_i,
   input  logic [PC_W-1:0]   pc_i,
   output logic              valid_o,
   output logic [INST_W-1:0] inst_o,
   output logic [PC_W-1:0]   pc_o
);
   logic              valid_q, valid_d;
   logic [INST_W-1:0] inst_q, inst_d;
   logic [PC_W-1:0]   pc_q, pc_d;

   always_comb begin
      valid_d = valid_q;
      inst_d  = inst_q;
      pc_d    = pc_q;
      if (clr_i) begin
         valid_d = 1'b0;
      end else begin
         if (pop_i) valid_d = 1'b0;
         if (push_i) begin
            valid_d = 1'b1;
            inst_d  = inst_i;
            pc_d    = pc_i;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         inst_q  <= '0;
         pc_q    <= '0;
      end else begin
         valid_q <= valid_d;
         inst_q  <= inst_d;
         pc_q    <= pc_d;
      end
   end

   assign valid_o = valid_q;
   assign inst_o  = inst_q;
   assign pc_o    = pc_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: issues sequential reads to a one-cycle-latency memory,
// buffers returns in an output register plus skid entry, handles redirect and HALT.
//
//   state  | meaning
//   IDLE   | after reset, waiting for start
//   FETCH  | issuing fetches and delivering instructions
//   DRAIN  | HALT captured, no more fetches, delivering up to and including HALT
//   HALTED | HALT accepted by decoder, waiting for start
module inst_fetch
   import TopLevel_def::*;
#(
   parameter int PC_W   = 10,
   parameter int INST_W = 9
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [PC_W-1:0]   start_addr,
   output logic [PC_W-1:0]   imem_addr,
   input  logic [INST_W-1:0] imem_data,
   input  logic              branch_taken,
   input  logic [PC_W-1:0]   branch_target,
   output logic [INST_W-1:0] out_inst,
   output logic [PC_W-1:0]   out_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              halted
);
   localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

   fetch_state_e      state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic              inflight_q, inflight_d;
   logic [PC_W-1:0]   fl_pc_q, fl_pc_d;
   logic              out_valid_q, out_valid_d;
   logic [INST_W-1:0] out_inst_q, out_inst_d;
   logic [PC_W-1:0]   out_pc_q, out_pc_d;

   logic              skid_valid, skid_push, skid_pop, skid_clr;
   logic [INST_W-1:0] skid_inst;
   logic [PC_W-1:0]   skid_pc;

   logic              waiting, active, redirect, accept, out_free;
   logic              in_valid, halt_cap, issue;
   logic [1:0]        occupancy;

   assign waiting   = (state_q == IDLE) || (state_q == HALTED);
   assign active    = (state_q == FETCH) || (state_q == DRAIN);
   assign redirect  = active && branch_taken;
   assign accept    = out_valid_q && out_ready;
   assign out_free  = !out_valid_q || accept;
   assign in_valid  = inflight_q && (state_q == FETCH);
   assign halt_cap  = in_valid && is_halt(imem_data[8:6], imem_data[1:0]);

   // An output entry being accepted this cycle frees its slot, which is what
   // lets a single outstanding fetch sustain one instruction per cycle.
   assign occupancy = {1'b0, out_valid_q && !out_ready} + {1'b0, skid_valid} + {1'b0, inflight_q};
   assign issue     = (state_q == FETCH) && !branch_taken && !halt_cap && (occupancy < 2'd2);

   assign inflight_d = issue;
   assign fl_pc_d    = issue ? pc_q : fl_pc_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, HALTED: if (start) state_d = FETCH;
         FETCH: begin
            if (branch_taken)  state_d = FETCH;
            else if (halt_cap) state_d = DRAIN;
         end
         DRAIN: begin
            if (branch_taken) state_d = FETCH;
            else if (accept && is_halt(out_inst_q[8:6], out_inst_q[1:0])) state_d = HALTED;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      pc_d = pc_q;
      if (waiting && start)  pc_d = start_addr;
      else if (redirect)     pc_d = branch_target;
      else if (issue)        pc_d = pc_q + PC_ONE;
   end

   // Skid entry is always older than the returning word, so it drains first.
   always_comb begin
      out_valid_d = out_valid_q;
      out_inst_d  = out_inst_q;
      out_pc_d    = out_pc_q;
      skid_push   = 1'b0;
      skid_pop    = 1'b0;
      skid_clr    = 1'b0;
      if (redirect) begin
         out_valid_d = 1'b0;
         skid_clr    = 1'b1;
      end else if (out_free) begin
         if (skid_valid) begin
            out_valid_d = 1'b1;
            out_inst_d  = skid_inst;
            out_pc_d    = skid_pc;
            skid_pop    = 1'b1;
            skid_push   = in_valid;
         end else if (in_valid) begin
            out_valid_d = 1'b1;
            out_inst_d  = imem_data;
            out_pc_d    = fl_pc_q;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (in_valid) begin
         skid_push = 1'b1;
      end
   end

   fetch_skid_buf #(
      .PC_W   (PC_W),
      .INST_W (INST_W)
   ) u_skid (
      .clk     (clk),
      .reset   (reset),
      .clr_i   (skid_clr),
      .push_i  (skid_push),
      .pop_i   (skid_pop),
      .inst_i  (imem_data),
      .pc_i    (fl_pc_q),
      .valid_o (skid_valid),
      .inst_o  (skid_inst),
      .pc_o    (skid_pc)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         pc_q        <= '0;
         inflight_q  <= 1'b0;
         fl_pc_q     <= '0;
         out_valid_q <= 1'b0;
         out_inst_q  <= '0;
         out_pc_q    <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         inflight_q  <= inflight_d;
         fl_pc_q     <= fl_pc_d;
         out_valid_q <= out_valid_d;
         out_inst_q  <= out_inst_d;
         out_pc_q    <= out_pc_d;
      end
   end

   assign imem_addr = pc_q;
   assign out_inst  = out_inst_q;
   assign out_pc    = out_pc_q;
   assign out_valid = out_valid_q;
   assign halted    = (state_q == HALTED);

endmodule
